// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter in front of a single-port synchronous memory. An
// instruction-fetch port (read only) and a data port (read/write) compete
// for the memory. Only one access is in flight at a time. The FSM walks
// IDLE -> ISSUE -> [WAIT] -> RESP -> IDLE. The owner's rvalid pulse lands in
// the IDLE cycle after RESP, and that same cycle can accept a new request.
//
// Parameters
//   ADDR_W   word-address width (requesters and memory)
//   DATA_W   data word width
//   MEM_LAT  memory read latency, 1..4 cycles from m_en to valid m_rdata
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   i_req, i_addr              fetch request, held until i_ack
//   i_ack, i_rvalid, i_rdata   fetch accept pulse, data-valid pulse, data
//   d_req, d_we, d_addr,
//   d_wdata                    data request, held until d_ack
//   d_ack, d_rvalid, d_rdata   data accept pulse, completion pulse, data
//   m_en, m_we, m_addr,
//   m_wdata, m_rdata           memory port
//   busy                       high while an access is in flight
//
// Optional feature (macro ARB_FAIR_EN)
//   When ARB_FAIR_EN is defined, a 2-bit starvation counter counts contested
//   grants that went to the data port. When it reaches 3, the next contested
//   grant goes to the fetch port. Any fetch grant clears the counter. When
//   the macro is undefined, the data port has strict priority.
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // WAIT lasts MEM_LAT-1 cycles. The counter starts at 0 on entry, so the
  // last WAIT cycle is the one where it reads MEM_LAT-2.
  localparam int         WAIT_LAST_I = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;
  localparam logic [1:0] WAIT_LAST   = WAIT_LAST_I[1:0];

  logic [1:0]        state, state_nxt;
  logic [1:0]        wait_cnt;
  logic              grant_i, grant_d;
  logic              favor_i;

  // Captured request; owner_d = 1 means the data port owns the access.
  logic              cap_owner_d;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;

  logic              i_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] i_rdata_q,  d_rdata_q;

`ifdef ARB_FAIR_EN
  logic [1:0] starve_cnt;
  assign favor_i = (starve_cnt == 2'd3);
`else
  assign favor_i = 1'b0;
`endif

  // Grant only in IDLE and never while reset is asserted, so the acks are
  // combinational pulses that cannot appear mid-access.
  always_comb begin
    // NOTE: every always_comb output gets a default first. A path that
    // leaves a signal unassigned would infer a latch.
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!reset && state == ST_IDLE) begin
      if (i_req && d_req) begin
        grant_i = favor_i;
        grant_d = !favor_i;
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant_i || grant_d) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = (MEM_LAT > 1) ? ST_WAIT : ST_RESP;
      ST_WAIT:  if (wait_cnt == WAIT_LAST) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments. Every register then samples
    // pre-edge values, whatever order these statements appear in.
    if (reset) begin
      state       <= ST_IDLE;
      wait_cnt    <= 2'd0;
      cap_owner_d <= 1'b0;
      cap_we      <= 1'b0;
      cap_addr    <= '0;
      cap_wdata   <= '0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state      <= state_nxt;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;

      if (grant_i || grant_d) begin
        cap_owner_d <= grant_d;
        cap_we      <= grant_d && d_we;
        cap_addr    <= grant_d ? d_addr : i_addr;
        cap_wdata   <= grant_d ? d_wdata : '0;
      end

      if (state == ST_WAIT) wait_cnt <= wait_cnt + 2'd1;
      else                  wait_cnt <= 2'd0;

      // A completed write returns zero on d_rdata.
      if (state == ST_RESP) begin
        if (cap_owner_d) begin
          d_rdata_q  <= cap_we ? '0 : m_rdata;
          d_rvalid_q <= 1'b1;
        end else begin
          i_rdata_q  <= m_rdata;
          i_rvalid_q <= 1'b1;
        end
      end
    end
  end

`ifdef ARB_FAIR_EN
  // Only contested data grants count. An uncontested data grant leaves the
  // counter alone.
  always_ff @(posedge clk) begin
    if (reset)                  starve_cnt <= 2'd0;
    else if (grant_i)           starve_cnt <= 2'd0;
    else if (grant_d && i_req)  starve_cnt <= starve_cnt + 2'd1;
  end
`endif

  assign i_ack    = grant_i;
  assign d_ack    = grant_d;
  assign i_rvalid = i_rvalid_q && !reset;
  assign d_rvalid = d_rvalid_q && !reset;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;

  // Address and write data keep driving the captured values. Only the
  // enables are limited to ISSUE, and reset suppresses them immediately.
  assign m_en    = (state == ST_ISSUE) && !reset;
  assign m_we    = m_en && cap_we;
  assign m_addr  = cap_addr;
  assign m_wdata = cap_wdata;
  assign busy    = (state != ST_IDLE) && !reset;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Two arbiter instances, MEM_LAT=1 (instance 0) and MEM_LAT=4 (instance 1),
// each with its own behavioural memory. A transaction-level reference model
// predicts the outputs for every cycle:
//   - a grant is allowed whenever the arbiter has been free since the last
//     grant plus MEM_LAT+2 cycles;
//   - the priority rule decides the winner;
//   - a grant yields m_en one cycle later and rvalid MEM_LAT+2 cycles later;
//   - the rvalid data comes from a reference memory array (zero for writes).
// Define ARB_FAIR_EN for both the RTL and this bench to exercise the
// fairness rule.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int NI     = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]     reset, i_req, d_req, d_we;
  logic [NI-1:0]     i_ack, i_rvalid, d_ack, d_rvalid, m_en, m_we, busy;
  logic [ADDR_W-1:0] i_addr [NI];
  logic [ADDR_W-1:0] d_addr [NI];
  logic [ADDR_W-1:0] m_addr [NI];
  logic [DATA_W-1:0] d_wdata [NI];
  logic [DATA_W-1:0] i_rdata [NI];
  logic [DATA_W-1:0] d_rdata [NI];
  logic [DATA_W-1:0] m_wdata [NI];
  logic [DATA_W-1:0] m_rdata [NI];

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic logic [DATA_W-1:0] init_word(int a);
    if (a == 32'h010) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g_inst
    localparam int LAT = (k == 0) ? 1 : 4;
    logic [DATA_W-1:0] mem  [DEPTH];
    logic [DATA_W-1:0] pipe [LAT];

    initial for (int a = 0; a < DEPTH; a++) mem[a] = init_word(a);

    always @(posedge clk) begin
      if (m_en[k] && m_we[k]) mem[m_addr[k]] <= m_wdata[k];
      pipe[0] <= (m_en[k] && !m_we[k]) ? mem[m_addr[k]] : 32'hBAD0BAD0;
      for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    end
    assign m_rdata[k] = pipe[LAT-1];

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(LAT)) u_dut (
      .clk      (clk),
      .reset    (reset[k]),
      .i_req    (i_req[k]),
      .i_addr   (i_addr[k]),
      .i_ack    (i_ack[k]),
      .i_rvalid (i_rvalid[k]),
      .i_rdata  (i_rdata[k]),
      .d_req    (d_req[k]),
      .d_we     (d_we[k]),
      .d_addr   (d_addr[k]),
      .d_wdata  (d_wdata[k]),
      .d_ack    (d_ack[k]),
      .d_rvalid (d_rvalid[k]),
      .d_rdata  (d_rdata[k]),
      .m_en     (m_en[k]),
      .m_we     (m_we[k]),
      .m_addr   (m_addr[k]),
      .m_wdata  (m_wdata[k]),
      .m_rdata  (m_rdata[k]),
      .busy     (busy[k])
    );
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cur_k    = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (inst %0d cycle %0d)",
               tag, got, exp, cur_k, cyc);
    end
  endtask

  // ---------------- requester state ----------------
  int                mode;   // 0 directed, 1 random, 2 saturating
  bit                iv, dv, dw;
  logic [ADDR_W-1:0] ia, da;
  logic [DATA_W-1:0] dd;

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                free_at, en_at, done_at, starve;
  bit                pend, p_owner_d, p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata, p_exp, last_i, last_d;
  int                n_igr, n_dgr;

  // ---------------- observations for directed checks ----------------
  int                obs_ack_cyc, obs_en_cyc, obs_rv_cyc, busy_cnt;
  int                n_obs_i, n_obs_irv;
  logic [DATA_W-1:0] obs_i_data, obs_d_data;

  task automatic model_init(input int k);
    cur_k   = k;
    cyc     = 0;
    free_at = 0;
    pend    = 1'b0;
    starve  = 0;
    last_i  = '0;
    last_d  = '0;
    iv = 1'b0; dv = 1'b0; dw = 1'b0; ia = '0; da = '0; dd = '0;
    mode = 0;
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = init_word(a);
  endtask

  task automatic apply_inputs(input int k);
    i_req[k]   = iv;
    i_addr[k]  = ia;
    d_req[k]   = dv;
    d_we[k]    = dw;
    d_addr[k]  = da;
    d_wdata[k] = dd;
  endtask

  task automatic refill();
    if (mode == 0) return;
    if (!iv && (mode == 2 || $urandom_range(0, 2) == 0)) begin
      iv = 1'b1;
      ia = ADDR_W'($urandom_range(0, 63));
    end
    if (!dv && (mode == 2 || $urandom_range(0, 2) == 0)) begin
      dv = 1'b1;
      dw = 1'($urandom_range(0, 1));
      da = ADDR_W'($urandom_range(0, 63));
      dd = $urandom;
    end
  endtask

  task automatic step();
    int k   = cur_k;
    int lat = lat_of(k);
    bit idle, ei, ed, erv;
    @(posedge clk);
    #1;
    reset[k] = 1'b0;
    apply_inputs(k);
    @(negedge clk);

    idle = (cyc >= free_at);
    ei = 1'b0;
    ed = 1'b0;
    if (idle) begin
      if (iv && dv) begin
`ifdef ARB_FAIR_EN
        if (starve == 3) ei = 1'b1;
        else begin ed = 1'b1; starve++; end
`else
        ed = 1'b1;
`endif
      end else begin
        ei = iv;
        ed = dv;
      end
      if (ei) starve = 0;
    end

    check("i_ack", i_ack[k], ei);
    check("d_ack", d_ack[k], ed);
    check("busy",  busy[k], !idle);
    check("m_en",  m_en[k], pend && cyc == en_at);
    if (pend && cyc == en_at) begin
      check("m_we",   m_we[k], p_we);
      check("m_addr", m_addr[k], p_addr);
      if (p_we) begin
        check("m_wdata", m_wdata[k], p_wdata);
        ref_mem[p_addr] = p_wdata;
      end
    end

    erv = pend && cyc == done_at;
    check("i_rvalid", i_rvalid[k], erv && !p_owner_d);
    check("d_rvalid", d_rvalid[k], erv && p_owner_d);
    if (erv) begin
      if (p_owner_d) last_d = p_exp;
      else           last_i = p_exp;
      pend = 1'b0;
    end
    check("i_rdata", i_rdata[k], last_i);
    check("d_rdata", d_rdata[k], last_d);

    if (i_ack[k] || d_ack[k]) obs_ack_cyc = cyc;
    if (i_ack[k])             n_obs_i++;
    if (m_en[k])              obs_en_cyc = cyc;
    if (i_rvalid[k]) begin obs_rv_cyc = cyc; obs_i_data = i_rdata[k]; n_obs_irv++; end
    if (d_rvalid[k]) begin obs_rv_cyc = cyc; obs_d_data = d_rdata[k]; end
    if (busy[k])             busy_cnt++;

    if (ei || ed) begin
      pend      = 1'b1;
      p_owner_d = ed;
      p_we      = ed && dw;
      p_addr    = ed ? da : ia;
      p_wdata   = p_we ? dd : '0;
      p_exp     = p_we ? '0 : ref_mem[p_addr];
      en_at     = cyc + 1;
      done_at   = cyc + lat + 2;
      free_at   = done_at;
      if (ei) begin iv = 1'b0; n_igr++; end
      else    begin dv = 1'b0; n_dgr++; end
    end
    refill();
    cyc++;
  endtask

  task automatic step_reset();
    int k = cur_k;
    @(posedge clk);
    #1;
    reset[k] = 1'b1;
    apply_inputs(k);
    @(negedge clk);
    check("rst_i_ack",    i_ack[k], 1'b0);
    check("rst_d_ack",    d_ack[k], 1'b0);
    check("rst_busy",     busy[k], 1'b0);
    check("rst_m_en",     m_en[k], 1'b0);
    check("rst_i_rvalid", i_rvalid[k], 1'b0);
    check("rst_d_rvalid", d_rvalid[k], 1'b0);
    pend    = 1'b0;
    free_at = cyc + 1;
    starve  = 0;
    last_i  = '0;
    last_d  = '0;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rst_cyc;
    reset = '1;
    i_req = '0; d_req = '0; d_we = '0;
    for (int k = 0; k < NI; k++) begin
      i_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      cur_k = k;
      check("por_busy",    busy[k], 1'b0);
      check("por_i_ack",   i_ack[k], 1'b0);
      check("por_m_en",    m_en[k], 1'b0);
      check("por_m_we",    m_we[k], 1'b0);
      check("por_m_addr",  m_addr[k], '0);
      check("por_i_rdata", i_rdata[k], '0);
      check("por_d_rdata", d_rdata[k], '0);
      check("por_rvalid",  {31'd0, i_rvalid[k] | d_rvalid[k]}, '0);
    end

    // ---------- instance 0: MEM_LAT = 1 ----------
    model_init(0);
    iv = 1'b1; ia = 12'h010;
    run(5);
    check("fetch_ack_cyc",  obs_ack_cyc, 0);
    check("fetch_m_en_cyc", obs_en_cyc, 1);
    check("fetch_rv_cyc",   obs_rv_cyc, 3);
    check("fetch_rdata",    obs_i_data, 32'hDEADBEEF);

    dv = 1'b1; dw = 1'b1; da = 12'h020; dd = 32'h12345678;
    run(4);
    check("wr_d_rdata", obs_d_data, 32'h0);
    dv = 1'b1; dw = 1'b0; da = 12'h020; dd = '0;
    run(4);
    check("rd_after_wr", obs_d_data, 32'h12345678);

    // Both requests held high the whole time.
    mode = 2; refill();
    n_obs_i = 0; n_igr = 0; n_dgr = 0;
    run(48);
`ifdef ARB_FAIR_EN
    check("sat_i_grants", n_obs_i, n_dgr / 3);
`else
    check("sat_i_grants", n_obs_i, 0);
`endif
    mode = 1;
    run(2000);
    mode = 0;
    run(20);

    // ---------- instance 1: MEM_LAT = 4 ----------
    model_init(1);
    step();
    iv = 1'b1; ia = 12'h040; busy_cnt = 0;
    run(9);
    check("lat4_rv_gap", obs_rv_cyc - obs_ack_cyc, 6);
    check("lat4_busy",   busy_cnt, 5);

    // Reset while a fetch sits in WAIT; a data request is pending.
    iv = 1'b1; ia = 12'h055;
    step();
    step();
    step();
    dv = 1'b1; dw = 1'b0; da = 12'h066;
    n_obs_irv = 0;
    rst_cyc = cyc;
    step_reset();
    step();
    check("post_rst_ack_cyc", obs_ack_cyc, rst_cyc + 1);
    run(10);
    check("post_rst_no_irv", n_obs_irv, 0);

    mode = 1;
    run(1500);
    mode = 0;
    run(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width shared by both requesters and the memory.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter MEM_LAT, default 1, legal 1..4, memory read latency in cycles from the m_en cycle to the cycle m_rdata is valid.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 i_req  in  1; i_addr  in  ADDR_W  instruction-fetch read request; held stable until i_ack.
REQ-007 i_ack  out  1; i_rvalid  out  1; i_rdata  out  DATA_W  fetch accept pulse, read-data valid pulse, read data.
REQ-008 d_req  in  1; d_we  in  1; d_addr  in  ADDR_W; d_wdata  in  DATA_W  data request; held stable until d_ack.
REQ-009 d_ack  out  1; d_rvalid  out  1; d_rdata  out  DATA_W  data accept pulse, completion pulse, read data.
REQ-010 m_en  out  1; m_we  out  1; m_addr  out  ADDR_W; m_wdata  out  DATA_W; m_rdata  in  DATA_W  single-port synchronous memory.
REQ-011 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-012 FSM states IDLE, ISSUE, WAIT, RESP; one access outstanding at a time.
REQ-013 IDLE: if any req high, grant one requester; its ack is high combinationally in that cycle; addr/we/wdata and owner captured; next state ISSUE.
REQ-014 At most one of i_ack, d_ack high in any cycle; ack is never high outside IDLE.
REQ-015 Arbitration: d wins when both requests are high, except as modified by REQ-027.
REQ-016 ISSUE: m_en=1, with m_addr, m_we, m_wdata driven from the captured registers for exactly one cycle; next state WAIT (MEM_LAT>1) or RESP (MEM_LAT=1).
REQ-017 WAIT: counter counts MEM_LAT-1 cycles; then RESP.
REQ-018 RESP: m_rdata registered into the owner's rdata register; next state IDLE.
REQ-019 Owner's rvalid high for exactly one cycle, the cycle after RESP, with rdata valid in that cycle; that cycle is IDLE and may ack a new request.
REQ-020 Ack-to-rvalid latency = MEM_LAT+2 cycles; peak throughput one access per MEM_LAT+2 cycles.
REQ-021 Writes: m_we=1 in ISSUE; d_rvalid still pulses per REQ-019; d_rdata for a write is 0.
REQ-022 m_en, m_we = 0 outside ISSUE; m_addr/m_wdata hold the captured values.
REQ-023 i_rdata/d_rdata hold their last value until the next completion to that port.
REQ-024 Requests arriving outside IDLE are not acked; requester waits.

Reset
REQ-025 reset high: state IDLE, busy=0, all ack/rvalid/m_en/m_we=0, rdata registers, capture registers and starvation counter=0.
REQ-026 reset mid-access: in-flight access dropped, no rvalid issued for it; a write already past ISSUE remains in memory.

Configuration
REQ-027 Macro ARB_FAIR_EN defined: 2-bit starvation counter increments each IDLE cycle where both req are high and d is granted; when it equals 3, the next contested grant goes to i; counter clears on any i grant.
REQ-028 ARB_FAIR_EN undefined: strict d priority, no counter; i can starve.

Verification
REQ-029 MEM_LAT=1, i_req addr 0x010 at cycle 0, mem[0x010]=0xDEADBEEF -> i_ack cycle 0, m_en cycle 1, i_rvalid cycle 3 with i_rdata=0xDEADBEEF.
REQ-030 d write addr 0x020 data 0x12345678, then d read 0x020 -> second access d_rdata=0x12345678; first d_rvalid with d_rdata=0.
REQ-031 i_req and d_req both held high continuously, ARB_FAIR_EN undefined -> only d acked; defined -> pattern d,d,d,i repeating.
REQ-032 MEM_LAT=4 read -> rvalid exactly 6 cycles after ack; busy high for 5 cycles.
REQ-033 reset asserted in WAIT -> no rvalid afterwards, busy=0 next cycle, pending req acked the first IDLE cycle after reset deasserts.
